receiver: RTL

UART receive stage: the downstream consumer of the transmitter's serial line in loopback and on the board's RX pin.
- Recovers 8N1 frames (start, DATA_WIDTH data bits LSB-first, one stop bit) using the shared 16x-oversampling tick from baudrate_generator (115200 baud at 50 MHz).
- Presents each recovered word with a one-cycle valid strobe.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/receiver.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry, board baud/clock constants,
// receiver state encoding and a counter-width helper.
package uart_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int OVERSAMPLE = 16;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115200;
    localparam int BIT_NS = 8680;

    // Receiver FSM encoding, kept as plain constants for legacy tools.
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    // Bits needed to count 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so an idle-high line can come out of reset
// looking idle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: preset to the idle level, otherwise release from reset
            // would look like a falling edge on the line.
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so the two stages form a real two-flop chain.
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/receiver.sv
// UART 8N1 receiver using a 16x oversampling tick.
// Start bit is confirmed at mid-bit, data bits are sampled at mid-bit
// LSB-first, and the stop bit is sampled SB_TICK ticks after the last data
// sample.
// Optional build macro RX_FRAMING_CHECK_EN adds the frame_err port and a
// WAIT_IDLE state that holds off new frames until the line returns high.
module receiver #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int SB_TICK    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_out,
    output logic                  rx_dv
`ifdef RX_FRAMING_CHECK_EN
    ,
    output logic                  frame_err
`endif
);

    import uart_pkg::*;

    // s_cnt must also reach SB_TICK-1 in the stop state.
    localparam int SW = clog2_min1((OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK);
    localparam int NW = clog2_min1(DATA_WIDTH);

    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_WIDTH - 1);

    logic                  w_rx_s;
    logic [2:0]            r_state;
    logic [SW-1:0]         r_s_cnt;
    logic [NW-1:0]         r_n_cnt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] r_rx_out;
    logic                  r_rx_dv;
`ifdef RX_FRAMING_CHECK_EN
    logic                  r_frame_err;
`endif

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx_in),
        .o_q (w_rx_s)
    );

    // Frame FSM: tick-paced counters, shift register and output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_s_cnt   <= '0;
            r_n_cnt   <= '0;
            r_shreg   <= '0;
            r_rx_out  <= '0;
            r_rx_dv   <= 1'b0;
`ifdef RX_FRAMING_CHECK_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            // NOTE: strobes default low each cycle, so a single assignment
            // below yields exactly one clock of valid.
            r_rx_dv <= 1'b0;
`ifdef RX_FRAMING_CHECK_EN
            r_frame_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_s_cnt <= '0;
                        r_state <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        if (r_s_cnt == S_HALF) begin
                            if (!w_rx_s) begin
                                r_s_cnt <= '0;
                                r_n_cnt <= '0;
                                r_state <= DATA;
                            end else begin
                                // Line went back high before mid-bit: glitch.
                                r_state <= IDLE;
                            end
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (r_s_cnt == S_LAST) begin
                            r_s_cnt <= '0;
                            r_shreg <= {w_rx_s, r_shreg[DATA_WIDTH-1:1]};
                            if (r_n_cnt == N_LAST) begin
                                r_state <= STOP;
                            end else begin
                                r_n_cnt <= r_n_cnt + 1'b1;
                            end
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (r_s_cnt == S_STOP) begin
`ifdef RX_FRAMING_CHECK_EN
                            if (w_rx_s) begin
                                r_rx_out <= r_shreg;
                                r_rx_dv  <= 1'b1;
                                r_state  <= IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= WAIT_IDLE;
                            end
`else
                            // Stop level is not checked in this build.
                            r_rx_out <= r_shreg;
                            r_rx_dv  <= 1'b1;
                            r_state  <= IDLE;
`endif
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end

`ifdef RX_FRAMING_CHECK_EN
                WAIT_IDLE: begin
                    // A held-low (break) line must not spawn back-to-back frames.
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
`endif

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rx_out = r_rx_out;
    assign rx_dv  = r_rx_dv;
`ifdef RX_FRAMING_CHECK_EN
    assign frame_err = r_frame_err;
`endif

endmodule
